// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding for the DLX core.
// Captures the decoded instruction and resolves RAW hazards by forwarding from MEM/WB.
// Load-use hazards and downstream holds stall decode; branch redirects kill the slot.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs1_val,
  input  logic [DATA_W-1:0] id_rs2_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [5:0]        id_func,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_hold,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_d1,
  output logic [DATA_W-1:0] ex_d2,
  output logic [5:0]        ex_func,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load
);

  // EX slot state
  logic              r_valid;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_rs1_val;
  logic [DATA_W-1:0] r_rs2_val;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [5:0]        r_func;
  logic              r_reg_write;
  logic              r_is_load;

  // Next-state values for the EX slot
  logic              w_nxt_valid;
  logic [RA_W-1:0]   w_nxt_rs1;
  logic [RA_W-1:0]   w_nxt_rs2;
  logic [RA_W-1:0]   w_nxt_rd;
  logic [DATA_W-1:0] w_nxt_rs1_val;
  logic [DATA_W-1:0] w_nxt_rs2_val;
  logic [DATA_W-1:0] w_nxt_imm;
  logic              w_nxt_use_imm;
  logic [5:0]        w_nxt_func;
  logic              w_nxt_reg_write;
  logic              w_nxt_is_load;

  // Forwarding and hazard terms
  logic              w_mem_can_fwd;
  logic              w_wb_can_fwd;
  logic              w_mem_hit1;
  logic              w_mem_hit2;
  logic              w_wb_hit1;
  logic              w_wb_hit2;
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;
  logic              w_ex_load_dep;
  logic              w_mem_load_dep;
  logic              w_hazard;

  // A load in MEM has no data yet, so it never acts as a forward source.
  assign w_mem_can_fwd = mem_valid && mem_reg_write && !mem_is_load && (mem_rd != '0);
  assign w_wb_can_fwd  = wb_valid && wb_reg_write && (wb_rd != '0);

  assign w_mem_hit1 = w_mem_can_fwd && (mem_rd == r_rs1);
  assign w_mem_hit2 = w_mem_can_fwd && (mem_rd == r_rs2);
  assign w_wb_hit1  = w_wb_can_fwd && (wb_rd == r_rs1);
  assign w_wb_hit2  = w_wb_can_fwd && (wb_rd == r_rs2);

  // Operand muxes: the younger MEM producer takes priority over WB.
  always_comb begin
    w_fwd1 = r_rs1_val;
    w_fwd2 = r_rs2_val;
    if (w_mem_hit1) begin
      w_fwd1 = mem_result;
    end else if (w_wb_hit1) begin
      w_fwd1 = wb_result;
    end
    if (w_mem_hit2) begin
      w_fwd2 = mem_result;
    end else if (w_wb_hit2) begin
      w_fwd2 = wb_result;
    end
  end

  // rs2 is always checked because stores read it even when d2 is the immediate.
  assign w_ex_load_dep  = r_valid && r_is_load && (r_rd != '0) &&
                          ((r_rd == id_rs1) || (r_rd == id_rs2));
  assign w_mem_load_dep = mem_valid && mem_is_load && mem_reg_write && (mem_rd != '0) &&
                          ((mem_rd == id_rs1) || (mem_rd == id_rs2));
  assign w_hazard       = id_valid && (w_ex_load_dep || w_mem_load_dep);

  assign id_stall = w_hazard || ex_hold;

  // Slot update priority: flush, then hold, then load-use bubble, then capture from ID.
  always_comb begin
    w_nxt_valid     = 1'b0;
    w_nxt_rs1       = '0;
    w_nxt_rs2       = '0;
    w_nxt_rd        = '0;
    w_nxt_rs1_val   = '0;
    w_nxt_rs2_val   = '0;
    w_nxt_imm       = '0;
    w_nxt_use_imm   = 1'b0;
    w_nxt_func      = '0;
    w_nxt_reg_write = 1'b0;
    w_nxt_is_load   = 1'b0;
    if (flush) begin
      w_nxt_valid = 1'b0;
    end else if (ex_hold) begin
      // Refresh the operands so a producer that retires during the hold is kept.
      w_nxt_valid     = r_valid;
      w_nxt_rs1       = r_rs1;
      w_nxt_rs2       = r_rs2;
      w_nxt_rd        = r_rd;
      w_nxt_rs1_val   = w_fwd1;
      w_nxt_rs2_val   = w_fwd2;
      w_nxt_imm       = r_imm;
      w_nxt_use_imm   = r_use_imm;
      w_nxt_func      = r_func;
      w_nxt_reg_write = r_reg_write;
      w_nxt_is_load   = r_is_load;
    end else if (w_hazard) begin
      w_nxt_valid = 1'b0;
    end else begin
      w_nxt_valid     = id_valid;
      w_nxt_rs1       = id_rs1;
      w_nxt_rs2       = id_rs2;
      w_nxt_rd        = id_rd;
      w_nxt_rs1_val   = id_rs1_val;
      w_nxt_rs2_val   = id_rs2_val;
      w_nxt_imm       = id_imm;
      w_nxt_use_imm   = id_use_imm;
      w_nxt_func      = id_func;
      w_nxt_reg_write = id_reg_write;
      w_nxt_is_load   = id_is_load;
    end
  end

  // EX slot register; reset leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_func      <= '0;
      r_reg_write <= 1'b0;
      r_is_load   <= 1'b0;
    end else begin
      r_valid     <= w_nxt_valid;
      r_rs1       <= w_nxt_rs1;
      r_rs2       <= w_nxt_rs2;
      r_rd        <= w_nxt_rd;
      r_rs1_val   <= w_nxt_rs1_val;
      r_rs2_val   <= w_nxt_rs2_val;
      r_imm       <= w_nxt_imm;
      r_use_imm   <= w_nxt_use_imm;
      r_func      <= w_nxt_func;
      r_reg_write <= w_nxt_reg_write;
      r_is_load   <= w_nxt_is_load;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_d1         = w_fwd1;
  assign ex_d2         = r_use_imm ? r_imm : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign ex_func       = r_func;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_is_load    = r_is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed vector table, async-reset sequence,
// then randomized traffic checked against a behavioural slot model.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        idValid;
    logic [4:0]  idRs1;
    logic [4:0]  idRs2;
    logic [4:0]  idRd;
    logic [31:0] idRs1Val;
    logic [31:0] idRs2Val;
    logic [31:0] idImm;
    logic        idUseImm;
    logic [5:0]  idFunc;
    logic        idRegWrite;
    logic        idIsLoad;
    logic        exHold;
    logic        flush;
    logic        memValid;
    logic        memRegWrite;
    logic        memIsLoad;
    logic [4:0]  memRd;
    logic [31:0] memResult;
    logic        wbValid;
    logic        wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbResult;
  } stimT;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] store;
    logic [5:0]  func;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
  } outT;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        useImm;
    logic [5:0]  func;
    logic        rw;
    logic        ld;
  } slotT;

  typedef struct {
    stimT stim;
    outT  exp;
  } vecT;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [5:0]  id_func;
  logic        id_reg_write;
  logic        id_is_load;
  logic        ex_hold;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_d1;
  logic [31:0] ex_d2;
  logic [5:0]  ex_func;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;

  int checkCount = 0;
  int passCount  = 0;

  ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_val    (id_rs1_val),
    .id_rs2_val    (id_rs2_val),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_func       (id_func),
    .id_reg_write  (id_reg_write),
    .id_is_load    (id_is_load),
    .ex_hold       (ex_hold),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_is_load   (mem_is_load),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .ex_d1         (ex_d1),
    .ex_d2         (ex_d2),
    .ex_func       (ex_func),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stimT idI(input stimT s, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic useImm, input logic [5:0] func,
                               input logic rw, input logic ld);
    stimT r;
    r = s;
    r.idValid = 1'b1;
    r.idRs1 = rs1;
    r.idRs2 = rs2;
    r.idRd = rd;
    r.idRs1Val = v1;
    r.idRs2Val = v2;
    r.idImm = imm;
    r.idUseImm = useImm;
    r.idFunc = func;
    r.idRegWrite = rw;
    r.idIsLoad = ld;
    return r;
  endfunction

  function automatic stimT memS(input stimT s, input logic [4:0] rd, input logic [31:0] res,
                                input logic ld);
    stimT r;
    r = s;
    r.memValid = 1'b1;
    r.memRegWrite = 1'b1;
    r.memIsLoad = ld;
    r.memRd = rd;
    r.memResult = res;
    return r;
  endfunction

  function automatic stimT wbS(input stimT s, input logic [4:0] rd, input logic [31:0] res);
    stimT r;
    r = s;
    r.wbValid = 1'b1;
    r.wbRegWrite = 1'b1;
    r.wbRd = rd;
    r.wbResult = res;
    return r;
  endfunction

  function automatic stimT ctl(input stimT s, input logic hold, input logic fl);
    stimT r;
    r = s;
    r.exHold = hold;
    r.flush = fl;
    return r;
  endfunction

  function automatic outT mkOut(input logic stall, input logic valid, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] store,
                                input logic [5:0] func, input logic [4:0] rd,
                                input logic rw, input logic ld);
    outT o;
    o.stall = stall;
    o.valid = valid;
    o.d1 = d1;
    o.d2 = d2;
    o.store = store;
    o.func = func;
    o.rd = rd;
    o.rw = rw;
    o.ld = ld;
    return o;
  endfunction

  // Reference model: operand value seen by the ALU for one source register.
  function automatic logic [31:0] fwdModel(input logic [4:0] rs, input logic [31:0] val,
                                           input stimT s);
    if (rs == 5'd0) return val;
    if (s.memValid && s.memRegWrite && !s.memIsLoad && s.memRd == rs) return s.memResult;
    if (s.wbValid && s.wbRegWrite && s.wbRd == rs) return s.wbResult;
    return val;
  endfunction

  function automatic logic readsReg(input logic [4:0] rd, input stimT s);
    return (rd != 5'd0) && (rd == s.idRs1 || rd == s.idRs2);
  endfunction

  function automatic logic hazardModel(input slotT st, input stimT s);
    logic exLoad;
    logic memLoad;
    exLoad  = st.valid && st.ld && readsReg(st.rd, s);
    memLoad = s.memValid && s.memIsLoad && s.memRegWrite && readsReg(s.memRd, s);
    return s.idValid && (exLoad || memLoad);
  endfunction

  function automatic outT modelOut(input slotT st, input stimT s);
    outT o;
    o.stall = hazardModel(st, s) || s.exHold;
    o.valid = st.valid;
    o.d1 = fwdModel(st.rs1, st.v1, s);
    o.store = fwdModel(st.rs2, st.v2, s);
    o.d2 = st.useImm ? st.imm : o.store;
    o.func = st.func;
    o.rd = st.rd;
    o.rw = st.rw;
    o.ld = st.ld;
    return o;
  endfunction

  function automatic slotT modelNext(input slotT st, input stimT s);
    slotT n;
    n = '0;
    if (s.flush) return n;
    if (s.exHold) begin
      n = st;
      n.v1 = fwdModel(st.rs1, st.v1, s);
      n.v2 = fwdModel(st.rs2, st.v2, s);
      return n;
    end
    if (hazardModel(st, s)) return n;
    n.valid = s.idValid;
    n.rs1 = s.idRs1;
    n.rs2 = s.idRs2;
    n.rd = s.idRd;
    n.v1 = s.idRs1Val;
    n.v2 = s.idRs2Val;
    n.imm = s.idImm;
    n.useImm = s.idUseImm;
    n.func = s.idFunc;
    n.rw = s.idRegWrite;
    n.ld = s.idIsLoad;
    return n;
  endfunction

  task automatic applyStimulus(input stimT s);
    id_valid      = s.idValid;
    id_rs1        = s.idRs1;
    id_rs2        = s.idRs2;
    id_rd         = s.idRd;
    id_rs1_val    = s.idRs1Val;
    id_rs2_val    = s.idRs2Val;
    id_imm        = s.idImm;
    id_use_imm    = s.idUseImm;
    id_func       = s.idFunc;
    id_reg_write  = s.idRegWrite;
    id_is_load    = s.idIsLoad;
    ex_hold       = s.exHold;
    flush         = s.flush;
    mem_valid     = s.memValid;
    mem_reg_write = s.memRegWrite;
    mem_is_load   = s.memIsLoad;
    mem_rd        = s.memRd;
    mem_result    = s.memResult;
    wb_valid      = s.wbValid;
    wb_reg_write  = s.wbRegWrite;
    wb_rd         = s.wbRd;
    wb_result     = s.wbResult;
  endtask

  task automatic cmpField(input string tag, input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s.%s actual=%h expected=%h", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input outT exp);
    cmpField(tag, "id_stall", 32'(id_stall), 32'(exp.stall));
    cmpField(tag, "ex_valid", 32'(ex_valid), 32'(exp.valid));
    cmpField(tag, "ex_d1", ex_d1, exp.d1);
    cmpField(tag, "ex_d2", ex_d2, exp.d2);
    cmpField(tag, "ex_store_data", ex_store_data, exp.store);
    cmpField(tag, "ex_func", 32'(ex_func), 32'(exp.func));
    cmpField(tag, "ex_rd", 32'(ex_rd), 32'(exp.rd));
    cmpField(tag, "ex_reg_write", 32'(ex_reg_write), 32'(exp.rw));
    cmpField(tag, "ex_is_load", 32'(ex_is_load), 32'(exp.ld));
  endtask

  // Main test sequence
  initial begin
    vecT  vecs[$];
    stimT idle;
    stimT s;
    stimT addR4;
    stimT holdId;
    stimT addDep;
    outT  zero;
    outT  holdOut;
    slotT model;

    idle = '0;
    zero = '0;
    rst_n = 1'b0;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Row 0: reset state
    vecs.push_back('{idle, zero});
    // Back-to-back RAW: ADD r3,r1,r2 then ADD r4,r3,r1 with r3 in MEM
    vecs.push_back('{idI(idle, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 6'h20, 1'b1, 1'b0), zero});
    addR4 = idI(idle, 5'd3, 5'd1, 5'd4, 32'd0, 32'd9, 32'd0, 1'b0, 6'h20, 1'b1, 1'b0);
    vecs.push_back('{addR4, mkOut(1'b0, 1'b1, 32'd5, 32'd7, 32'd7, 6'h20, 5'd3, 1'b1, 1'b0)});
    s = memS(idI(idle, 5'd5, 5'd5, 5'd6, 32'h11, 32'h22, 32'h100, 1'b1, 6'h21, 1'b1, 1'b0),
             5'd3, 32'h10, 1'b0);
    vecs.push_back('{s, mkOut(1'b0, 1'b1, 32'h10, 32'd9, 32'd9, 6'h20, 5'd4, 1'b1, 1'b0)});
    // Double hit on r5: MEM wins; d2 takes the immediate
    s = wbS(memS(idI(idle, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 32'd0, 1'b0, 6'h22, 1'b1, 1'b0),
                 5'd5, 32'hAAAA, 1'b0), 5'd5, 32'hBBBB);
    vecs.push_back('{s, mkOut(1'b0, 1'b1, 32'hAAAA, 32'h100, 32'hAAAA, 6'h21, 5'd6, 1'b1, 1'b0)});
    // Double hit on r0: registered values pass through
    s = wbS(memS(idI(idle, 5'd8, 5'd9, 5'd10, 32'h55, 32'h66, 32'd0, 1'b0, 6'h23, 1'b1, 1'b0),
                 5'd0, 32'hAAAA, 1'b0), 5'd0, 32'hBBBB);
    vecs.push_back('{s, mkOut(1'b0, 1'b1, 32'h33, 32'h44, 32'h44, 6'h22, 5'd7, 1'b1, 1'b0)});
    // MEM load on r8 cannot forward, WB supplies r8; LW r2 enters ID
    s = wbS(memS(idI(idle, 5'd1, 5'd0, 5'd2, 32'h1000, 32'd0, 32'd4, 1'b1, 6'h20, 1'b1, 1'b1),
                 5'd8, 32'hCCCC, 1'b1), 5'd8, 32'hDDDD);
    vecs.push_back('{s, mkOut(1'b0, 1'b1, 32'hDDDD, 32'h66, 32'h66, 6'h23, 5'd10, 1'b1, 1'b0)});
    // Load-use: ADD r11,r2,r3 stalls twice then takes r2 from WB
    addDep = idI(idle, 5'd2, 5'd3, 5'd11, 32'd0, 32'd7, 32'd0, 1'b0, 6'h20, 1'b1, 1'b0);
    vecs.push_back('{addDep, mkOut(1'b1, 1'b1, 32'h1000, 32'd4, 32'd0, 6'h20, 5'd2, 1'b1, 1'b1)});
    vecs.push_back('{memS(addDep, 5'd2, 32'd0, 1'b1), mkOut(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 6'h0, 5'd0, 1'b0, 1'b0)});
    vecs.push_back('{wbS(addDep, 5'd2, 32'h12345678), zero});
    vecs.push_back('{wbS(idle, 5'd2, 32'h12345678),
                     mkOut(1'b0, 1'b1, 32'h12345678, 32'd7, 32'd7, 6'h20, 5'd11, 1'b1, 1'b0)});
    // Hold capture: WB producer of r12 retires during a 3-cycle hold
    vecs.push_back('{idI(idle, 5'd12, 5'd13, 5'd14, 32'd0, 32'h77, 32'd0, 1'b0, 6'h24, 1'b1, 1'b0), zero});
    holdId = idI(idle, 5'd1, 5'd1, 5'd15, 32'd1, 32'd2, 32'd0, 1'b0, 6'h25, 1'b1, 1'b0);
    holdOut = mkOut(1'b1, 1'b1, 32'hDEADBEEF, 32'h77, 32'h77, 6'h24, 5'd14, 1'b1, 1'b0);
    vecs.push_back('{ctl(wbS(holdId, 5'd12, 32'hDEADBEEF), 1'b1, 1'b0), holdOut});
    vecs.push_back('{ctl(holdId, 1'b1, 1'b0), holdOut});
    vecs.push_back('{ctl(holdId, 1'b1, 1'b0), holdOut});
    holdOut.stall = 1'b0;
    vecs.push_back('{holdId, holdOut});
    // Flush with hold: flush wins
    vecs.push_back('{ctl(idle, 1'b1, 1'b1), mkOut(1'b1, 1'b1, 32'd1, 32'd2, 32'd2, 6'h25, 5'd15, 1'b1, 1'b0)});
    vecs.push_back('{idI(idle, 5'd0, 5'd0, 5'd20, 32'h200, 32'd0, 32'd8, 1'b1, 6'h20, 1'b1, 1'b1), zero});
    // Flush with load-use hazard: bubble, stall stays high this cycle
    s = idI(idle, 5'd20, 5'd0, 5'd21, 32'h300, 32'h301, 32'd0, 1'b0, 6'h26, 1'b1, 1'b0);
    vecs.push_back('{ctl(s, 1'b0, 1'b1), mkOut(1'b1, 1'b1, 32'h200, 32'd8, 32'd0, 6'h20, 5'd20, 1'b1, 1'b1)});
    vecs.push_back('{s, zero});
    vecs.push_back('{idle, mkOut(1'b0, 1'b1, 32'h300, 32'h301, 32'h301, 6'h26, 5'd21, 1'b1, 1'b0)});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      #4;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Async reset in the middle of a load-use stall
    applyStimulus(idI(idle, 5'd0, 5'd0, 5'd22, 32'h400, 32'd0, 32'd0, 1'b1, 6'h20, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    applyStimulus(idI(idle, 5'd22, 5'd0, 5'd23, 32'd0, 32'd0, 32'd0, 1'b0, 6'h20, 1'b1, 1'b0));
    #4;
    checkOutput("rstPre", mkOut(1'b1, 1'b1, 32'h400, 32'd0, 32'd0, 6'h20, 5'd22, 1'b1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsync", zero);
    applyStimulus(idle);
    #1;
    checkOutput("rstIdle", zero);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #4;
    checkOutput("rstResume", zero);
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    model = '0;
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.idValid     = ($urandom_range(0, 99) < 80);
      s.idRs1       = 5'($urandom_range(0, 3));
      s.idRs2       = 5'($urandom_range(0, 3));
      s.idRd        = 5'($urandom_range(0, 3));
      s.idRs1Val    = $urandom;
      s.idRs2Val    = $urandom;
      s.idImm       = $urandom;
      s.idUseImm    = ($urandom_range(0, 99) < 40);
      s.idFunc      = 6'($urandom_range(0, 63));
      s.idRegWrite  = ($urandom_range(0, 99) < 80);
      s.idIsLoad    = ($urandom_range(0, 99) < 30);
      s.exHold      = ($urandom_range(0, 99) < 15);
      s.flush       = ($urandom_range(0, 99) < 8);
      s.memValid    = ($urandom_range(0, 99) < 60);
      s.memRegWrite = ($urandom_range(0, 99) < 80);
      s.memIsLoad   = ($urandom_range(0, 99) < 30);
      s.memRd       = 5'($urandom_range(0, 3));
      s.memResult   = $urandom;
      s.wbValid     = ($urandom_range(0, 99) < 60);
      s.wbRegWrite  = ($urandom_range(0, 99) < 80);
      s.wbRd        = 5'($urandom_range(0, 3));
      s.wbResult    = $urandom;
      applyStimulus(s);
      #4;
      checkOutput($sformatf("rand%0d", i), modelOut(model, s));
      @(posedge clk);
      model = modelNext(model, s);
      #1;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the pipelined DLX core. It sits directly upstream of the ALU and feeds its `d1`, `d2` and `func` inputs. It captures decoded instructions, resolves RAW hazards by forwarding from MEM and WB, and inserts bubbles on load-use hazards. It also honours downstream hold and branch flush.

## Interface
- `DATA_W`, 32, operand width
- `RA_W`, 5, register-address width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `id_valid` in 1: decode slot holds an instruction
- `id_rs1`, `id_rs2` in RA_W: source register numbers
- `id_rd` in RA_W: destination register number
- `id_rs1_val`, `id_rs2_val` in DATA_W: register-file read data
- `id_imm` in DATA_W: sign/zero-extended immediate
- `id_use_imm` in 1: `d2` takes the immediate instead of rs2
- `id_func` in 6: ALU function code
- `id_reg_write`, `id_is_load` in 1: instruction attributes
- `ex_hold` in 1: downstream stall, freezes the EX slot
- `flush` in 1: branch redirect, kills the EX slot
- `mem_valid`, `mem_reg_write`, `mem_is_load` in 1; `mem_rd` in RA_W; `mem_result` in DATA_W: MEM-stage forward source
- `wb_valid`, `wb_reg_write` in 1; `wb_rd` in RA_W; `wb_result` in DATA_W: WB-stage forward source
- `id_stall` out 1: decode must hold its instruction this cycle
- `ex_valid` out 1: EX slot valid
- `ex_d1`, `ex_d2` out DATA_W: ALU operands after forwarding
- `ex_func` out 6: ALU function code
- `ex_store_data` out DATA_W: forwarded rs2, for stores
- `ex_rd` out RA_W; `ex_reg_write`, `ex_is_load` out 1: passed to EX/MEM

## Operation
- **EX slot registers:** valid, rs1, rs2, rd, rs1_val, rs2_val, imm, use_imm, func, reg_write, is_load.
- **Forward source "hit":** the source is valid, has reg_write set, its rd is nonzero, and its rd equals the slot's rs.
- **Forwarding for each source (`fwd(rs, val)`), highest priority first:**
  - MEM hit with `!mem_is_load` → `mem_result`
  - WB hit → `wb_result`
  - otherwise → the registered `val`
  - Register 0 is never forwarded.
- **Operand outputs:**
  - `ex_d1` = fwd(rs1)
  - `ex_store_data` = fwd(rs2)
  - `ex_d2` = `use_imm` ? imm : fwd(rs2)
- **Hazard:** `id_valid` is set, and either
  - the EX slot is valid with `ex_is_load`, or
  - MEM is valid with `mem_is_load` and `mem_reg_write`,
  - and that load's rd is nonzero and equals `id_rs1` or `id_rs2`. rs2 is always checked, because stores consume it.
- **`id_stall`** = hazard | `ex_hold`.
- **Next-state update, per clock, in priority order:**
  1. `flush` → bubble.
  2. `ex_hold` → keep all fields. rs1_val and rs2_val are overwritten with their current forwarded values, so a producer retiring during the hold is not lost.
  3. hazard → bubble.
  4. else → load the ID fields. `ex_valid` takes `id_valid`.
- **Bubble:** valid, reg_write and is_load cleared; rd = 0; func = 0; operand registers cleared.
- A load-use stall lasts exactly 2 cycles: the load in EX, then the load in MEM. The dependant then enters EX with the load in WB and takes `wb_result`.
- No arithmetic is performed; all widths pass through unchanged.

## Timing
- **Reset:** `rst_n` low asynchronously forces a bubble. All outputs read 0 until the first valid capture, except `id_stall`, which follows its combinational terms (0 with inputs idle).
- **Latency:** one cycle from ID capture to EX outputs.
- **Combinational paths:**
  - forward muxes: mem/wb inputs → `ex_d1`, `ex_d2`, `ex_store_data`
  - `id_stall`: ID, EX and MEM fields → `id_stall`
- **Simultaneous events:**
  - `flush` with `ex_hold` → flush wins.
  - `flush` with hazard → bubble; `id_stall` stays asserted because the hazard still holds.
- **Reset mid-stall:** the pipeline resumes from a bubble with no residual stall.

## Test plan
1. **Back-to-back RAW:** ADD r3 then ADD r4,r3,r1. `mem_result` = 0x0000_0010 is present for r3 → `ex_d1` = 0x10. The registered stale value 0x0 is ignored.
2. **Double hit:** MEM and WB both target r5 with values 0xAAAA and 0xBBBB → `ex_d1` = 0xAAAA. With rd = 0 on both → the registered value passes through.
3. **Load-use:** LW r2 followed by ADD using r2 → `id_stall` is high for 2 cycles, two bubbles appear (`ex_valid` = 0), then the ADD enters EX with `ex_d1` = `wb_result` (0x1234_5678).
4. **Hold capture:** hold EX for 3 cycles while the WB producer of rs1 (0xDEAD_BEEF) retires in cycle 1 → after release, `ex_d1` is still 0xDEAD_BEEF.
5. **Flush priority:** `flush` and `ex_hold` asserted together → the next cycle has `ex_valid` = 0, `ex_reg_write` = 0 and `ex_rd` = 0.
6. **Async reset:** drop `rst_n` mid-cycle during a stall → the outputs clear immediately without waiting for a clock, and `id_stall` is 0 once the inputs are idle.
